// File: rtl/biriscv_iq_pkg.sv
// Shared widths, info-bit indices and entry layout for the dual-issue instruction queue.
package biriscv_iq_pkg;

    localparam int IQ_INFO_W       = 8;
    localparam int IQ_INFO_EXEC    = 0;
    localparam int IQ_INFO_LSU     = 1;
    localparam int IQ_INFO_BRANCH  = 2;
    localparam int IQ_INFO_MUL     = 3;
    localparam int IQ_INFO_DIV     = 4;
    localparam int IQ_INFO_CSR     = 5;
    localparam int IQ_INFO_RD_VALID = 6;
    localparam int IQ_INFO_INVALID = 7;

    localparam int IQ_FAULT_W = 2;
    localparam int IQ_ENTRY_W = IQ_INFO_W + IQ_FAULT_W + 32 + 32;

    // Packing order {info, fault, pc, instr}
    typedef struct packed {
        logic [IQ_INFO_W-1:0]  info;
        logic [IQ_FAULT_W-1:0] fault;
        logic [31:0]           pc;
        logic [31:0]           instr;
    } iq_entry_t;

endpackage

// File: rtl/biriscv_iq_ram.sv
// DEPTH-entry register array for the instruction queue: two write ports, two async read ports.
module biriscv_iq_ram
    import biriscv_iq_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DEPTH_W = 3
)(
    input  logic               clk_i,
    input  logic               wr0_en_i,
    input  logic [DEPTH_W-1:0] wr0_addr_i,
    input  iq_entry_t          wr0_data_i,
    input  logic               wr1_en_i,
    input  logic [DEPTH_W-1:0] wr1_addr_i,
    input  iq_entry_t          wr1_data_i,
    input  logic [DEPTH_W-1:0] rd0_addr_i,
    output iq_entry_t          rd0_data_o,
    input  logic [DEPTH_W-1:0] rd1_addr_i,
    output iq_entry_t          rd1_data_o
);

    iq_entry_t ram_q [DEPTH];

    // Payload is not reset; validity comes entirely from the top's count.
    always_ff @(posedge clk_i) begin
        if (wr0_en_i) ram_q[wr0_addr_i] <= wr0_data_i;
        if (wr1_en_i) ram_q[wr1_addr_i] <= wr1_data_i;
    end

    assign rd0_data_o = ram_q[rd0_addr_i];
    assign rd1_data_o = ram_q[rd1_addr_i];

endmodule

// File: rtl/biriscv_inst_queue.sv
// Dual-issue instruction queue between fetch and issue; flushed on branch_request_i.
// Optional sticky fault squash enabled by defining BIRISCV_IQ_FAULT_SQUASH_EN.
module biriscv_inst_queue
    import biriscv_iq_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DEPTH_W = 3
)(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  branch_request_i,
    input  logic                  in0_valid_i,
    input  logic [31:0]           in0_instr_i,
    input  logic [31:0]           in0_pc_i,
    input  logic [IQ_FAULT_W-1:0] in0_fault_i,
    input  logic [IQ_INFO_W-1:0]  in0_info_i,
    output logic                  in0_accept_o,
    input  logic                  in1_valid_i,
    input  logic [31:0]           in1_instr_i,
    input  logic [31:0]           in1_pc_i,
    input  logic [IQ_FAULT_W-1:0] in1_fault_i,
    input  logic [IQ_INFO_W-1:0]  in1_info_i,
    output logic                  in1_accept_o,
    output logic                  out0_valid_o,
    output logic [31:0]           out0_instr_o,
    output logic [31:0]           out0_pc_o,
    output logic [IQ_FAULT_W-1:0] out0_fault_o,
    output logic [IQ_INFO_W-1:0]  out0_info_o,
    input  logic                  out0_accept_i,
    output logic                  out1_valid_o,
    output logic [31:0]           out1_instr_o,
    output logic [31:0]           out1_pc_o,
    output logic [IQ_FAULT_W-1:0] out1_fault_o,
    output logic [IQ_INFO_W-1:0]  out1_info_o,
    input  logic                  out1_accept_i,
    output logic [DEPTH_W:0]      count_o
);

    logic [DEPTH_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_W:0]   count_q;
    logic               squash_q;
    logic               space0, space1;
    logic               push0, push1, pop0, pop1;
    iq_entry_t          wr0_data, wr1_data, rd0_data, rd1_data;

    assign space0 = (count_q <= (DEPTH_W+1)'(DEPTH-1));
    assign space1 = (count_q <= (DEPTH_W+1)'(DEPTH-2));

    // Squashed fetch is still accepted (so fetch drains) but never written.
    assign in0_accept_o = space0 | squash_q;
    assign in1_accept_o = space1 | squash_q;

    assign push0 = in0_valid_i & space0 & ~squash_q;
    assign push1 = in1_valid_i & space1 & push0;

    assign out0_valid_o = (count_q >= (DEPTH_W+1)'(1));
    assign out1_valid_o = (count_q >= (DEPTH_W+1)'(2));

    assign pop0 = out0_valid_o & out0_accept_i;
    assign pop1 = out1_valid_o & out1_accept_i & pop0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (branch_request_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + DEPTH_W'(push0) + DEPTH_W'(push1);
            rd_ptr_q <= rd_ptr_q + DEPTH_W'(pop0) + DEPTH_W'(pop1);
            count_q  <= count_q + (DEPTH_W+1)'(push0) + (DEPTH_W+1)'(push1)
                                - (DEPTH_W+1)'(pop0) - (DEPTH_W+1)'(pop1);
        end
    end

`ifdef BIRISCV_IQ_FAULT_SQUASH_EN
    // Flush wins over a faulted push in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            squash_q <= 1'b0;
        else if (branch_request_i)
            squash_q <= 1'b0;
        else if ((push0 & |in0_fault_i) | (push1 & |in1_fault_i))
            squash_q <= 1'b1;
    end
`else
    assign squash_q = 1'b0;
`endif

    assign wr0_data = '{info: in0_info_i, fault: in0_fault_i, pc: in0_pc_i, instr: in0_instr_i};
    assign wr1_data = '{info: in1_info_i, fault: in1_fault_i, pc: in1_pc_i, instr: in1_instr_i};

    biriscv_iq_ram #(.DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) u_ram (
        .clk_i      (clk_i),
        .wr0_en_i   (push0 & ~branch_request_i),
        .wr0_addr_i (wr_ptr_q),
        .wr0_data_i (wr0_data),
        .wr1_en_i   (push1 & ~branch_request_i),
        .wr1_addr_i (wr_ptr_q + DEPTH_W'(1)),
        .wr1_data_i (wr1_data),
        .rd0_addr_i (rd_ptr_q),
        .rd0_data_o (rd0_data),
        .rd1_addr_i (rd_ptr_q + DEPTH_W'(1)),
        .rd1_data_o (rd1_data)
    );

    assign out0_instr_o = out0_valid_o ? rd0_data.instr : '0;
    assign out0_pc_o    = out0_valid_o ? rd0_data.pc    : '0;
    assign out0_fault_o = out0_valid_o ? rd0_data.fault : '0;
    assign out0_info_o  = out0_valid_o ? rd0_data.info  : '0;
    assign out1_instr_o = out1_valid_o ? rd1_data.instr : '0;
    assign out1_pc_o    = out1_valid_o ? rd1_data.pc    : '0;
    assign out1_fault_o = out1_valid_o ? rd1_data.fault : '0;
    assign out1_info_o  = out1_valid_o ? rd1_data.info  : '0;

    assign count_o = count_q;

    a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        count_q <= (DEPTH_W+1)'(DEPTH))
        else $error("instruction queue count overflow");

endmodule

// File: tb/tb_biriscv_inst_queue.sv
// Randomized + directed bench for biriscv_inst_queue against a queue-based reference model.
module tb_biriscv_inst_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [31:0] ins0 = '0, ins1 = '0, pc0 = '0, pc1 = '0;
    logic [1:0]  f0 = '0, f1 = '0;
    logic [7:0]  inf0 = '0, inf1 = '0;
    logic        a0 = 1'b0, a1 = 1'b0;
    logic        acc0, acc1;
    logic        ov0, ov1;
    logic [31:0] oins0, oins1, opc0, opc1;
    logic [1:0]  of0, of1;
    logic [7:0]  oinf0, oinf1;
    logic [3:0]  cnt;

    always #5 clk = ~clk;

    biriscv_inst_queue #(.DEPTH(8), .DEPTH_W(3)) dut (
        .clk_i(clk), .rst_i(rst), .branch_request_i(br),
        .in0_valid_i(v0), .in0_instr_i(ins0), .in0_pc_i(pc0), .in0_fault_i(f0), .in0_info_i(inf0),
        .in0_accept_o(acc0),
        .in1_valid_i(v1), .in1_instr_i(ins1), .in1_pc_i(pc1), .in1_fault_i(f1), .in1_info_i(inf1),
        .in1_accept_o(acc1),
        .out0_valid_o(ov0), .out0_instr_o(oins0), .out0_pc_o(opc0), .out0_fault_o(of0), .out0_info_o(oinf0),
        .out0_accept_i(a0),
        .out1_valid_o(ov1), .out1_instr_o(oins1), .out1_pc_o(opc1), .out1_fault_o(of1), .out1_info_o(oinf1),
        .out1_accept_i(a1),
        .count_o(cnt)
    );

    int          checks = 0, passed = 0;
    logic [73:0] q[$];
    bit          sq = 0;
    bit          rnd_fault = 0;
    logic [31:0] pc_seq = '0;
    logic [31:0] dut_pops[$];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_in(input bit iv0, input bit iv1, input bit ia0, input bit ia1,
                          input bit ibr, input logic [1:0] if0);
        v0 = iv0; v1 = iv1; a0 = ia0; a1 = ia1; br = ibr;
        pc0 = pc_seq; pc1 = pc_seq + 32'd4;
        ins0 = $urandom; ins1 = $urandom;
        inf0 = 8'($urandom); inf1 = 8'($urandom);
        f0 = if0;
        f1 = rnd_fault ? 2'($urandom) : 2'b00;
    endtask

    // The model: a FIFO of whole entries; occupancy is just its size.
    task automatic model_update();
        int n = q.size();
        bit s0 = (n <= 7), s1 = (n <= 6);
        bit p0, p1, u0, u1;
        if (br) begin
            q.delete();
            sq = 0;
            return;
        end
        p0 = (n >= 1) && a0;
        p1 = (n >= 2) && a1 && p0;
        u0 = v0 && s0 && !sq;
        u1 = v1 && s1 && u0;
        if (p0) void'(q.pop_front());
        if (p1) void'(q.pop_front());
        if (u0) begin q.push_back({inf0, f0, pc0, ins0}); pc_seq += 32'd4; end
        if (u1) begin q.push_back({inf1, f1, pc1, ins1}); pc_seq += 32'd4; end
`ifdef BIRISCV_IQ_FAULT_SQUASH_EN
        if ((u0 && f0 != 0) || (u1 && f1 != 0)) sq = 1;
`endif
    endtask

    task automatic compare();
        int n = q.size();
        chk("count", 80'(cnt), 80'(n));
        chk("out0_valid", 80'(ov0), 80'(n >= 1));
        chk("out1_valid", 80'(ov1), 80'(n >= 2));
        chk("out0_entry", 80'({oinf0, of0, opc0, oins0}), 80'((n >= 1) ? q[0] : 74'd0));
        chk("out1_entry", 80'({oinf1, of1, opc1, oins1}), 80'((n >= 2) ? q[1] : 74'd0));
        chk("in0_accept", 80'(acc0), 80'(sq || n <= 7));
        chk("in1_accept", 80'(acc1), 80'(sq || n <= 6));
    endtask

    // Inputs are already driven; log what the DUT hands over, clock, then check.
    task automatic cycle();
        #1;
        if (!br && ov0 && a0) begin
            dut_pops.push_back(opc0);
            if (ov1 && a1) dut_pops.push_back(opc1);
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic drain();
        set_in(0, 0, 1, 1, 0, 2'b00);
        for (int i = 0; i < 20 && q.size() > 0; i++) cycle();
        chk("drain_empty", 80'(cnt), 80'd0);
    endtask

    initial begin
        #2;
        chk("rst_count", 80'(cnt), 80'd0);
        chk("rst_out0_valid", 80'(ov0), 80'd0);
        chk("rst_out1_valid", 80'(ov1), 80'd0);
        chk("rst_accepts", 80'({acc0, acc1}), 80'b11);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-traffic
        pc_seq = 32'h40;
        set_in(1, 1, 0, 0, 0, 2'b00); cycle();
        set_in(1, 1, 0, 0, 0, 2'b00); cycle();
        set_in(1, 0, 0, 0, 0, 2'b00); cycle();
        chk("pre_rst_count", 80'(cnt), 80'd5);
        set_in(0, 0, 0, 0, 0, 2'b00);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_count", 80'(cnt), 80'd0);
        chk("async_rst_valids", 80'({ov0, ov1}), 80'b00);
        chk("async_rst_accepts", 80'({acc0, acc1}), 80'b11);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        sq = 0;

        // Dual push then dual pop
        pc_seq = 32'h8000_0000;
        set_in(1, 1, 0, 0, 0, 2'b00); cycle();
        chk("dual_out0_pc", 80'(opc0), 80'h8000_0000);
        chk("dual_out1_pc", 80'(opc1), 80'h8000_0004);
        set_in(1, 1, 0, 0, 0, 2'b00); cycle();
        chk("dual_count4", 80'(cnt), 80'd4);
        set_in(0, 0, 1, 1, 0, 2'b00); cycle();
        chk("dual_pop_pc", 80'(opc0), 80'h8000_0008);
        chk("dual_count2", 80'(cnt), 80'd2);
        cycle();
        chk("dual_count0", 80'(cnt), 80'd0);

        // Full boundary
        for (int i = 0; i < 3; i++) begin set_in(1, 1, 0, 0, 0, 2'b00); cycle(); end
        set_in(1, 0, 0, 0, 0, 2'b00); cycle();
        chk("full7_count", 80'(cnt), 80'd7);
        chk("full7_accepts", 80'({acc0, acc1}), 80'b10);
        set_in(1, 1, 0, 0, 0, 2'b00); cycle();
        chk("full8_count", 80'(cnt), 80'd8);
        set_in(1, 1, 1, 0, 0, 2'b00);
        #1;
        chk("full_pop_no_accept", 80'({acc0, acc1}), 80'b00);
        cycle();
        chk("full_pop_count", 80'(cnt), 80'd7);
        drain();

        // Wrap order: push-2 / pop-1 then drain
        pc_seq = 32'h1000;
        dut_pops.delete();
        for (int i = 0; i < 20; i++) begin set_in(1, 1, 1, 0, 0, 2'b00); cycle(); end
        drain();
        chk("wrap_first", 80'(dut_pops[0]), 80'h1000);
        chk("wrap_total", 80'(dut_pops.size()), 80'((pc_seq - 32'h1000) / 4));
        for (int i = 1; i < dut_pops.size(); i++)
            chk("wrap_order", 80'(dut_pops[i]), 80'(dut_pops[i-1] + 32'd4));

        // Flush collision
        for (int i = 0; i < 3; i++) begin set_in(1, 1, 0, 0, 0, 2'b00); cycle(); end
        chk("flush_pre_count", 80'(cnt), 80'd6);
        set_in(1, 1, 1, 0, 1, 2'b00); cycle();
        chk("flush_count", 80'(cnt), 80'd0);
        chk("flush_valids", 80'({ov0, ov1}), 80'b00);
        pc_seq = 32'h3000;
        set_in(1, 1, 0, 0, 0, 2'b00); cycle();
        chk("post_flush_count", 80'(cnt), 80'd2);
        chk("post_flush_pc", 80'(opc0), 80'h3000);

`ifdef BIRISCV_IQ_FAULT_SQUASH_EN
        set_in(0, 0, 0, 0, 1, 2'b00); cycle();
        pc_seq = 32'h100;
        set_in(1, 0, 0, 0, 0, 2'b01); cycle();
        for (int i = 0; i < 3; i++) begin set_in(1, 1, 0, 0, 0, 2'b00); cycle(); end
        chk("squash_count", 80'(cnt), 80'd1);
        chk("squash_pc", 80'(opc0), 80'h100);
        chk("squash_accepts", 80'({acc0, acc1}), 80'b11);
        set_in(0, 0, 0, 0, 1, 2'b00); cycle();
        pc_seq = 32'h200;
        set_in(1, 0, 0, 0, 0, 2'b00); cycle();
        chk("squash_clear_pc", 80'(opc0), 80'h200);
        chk("squash_clear_count", 80'(cnt), 80'd1);
`endif

        // Randomized traffic
        rnd_fault = 1;
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 24) == 0), 2'($urandom));
            cycle();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
